// File: rtl/sa_down_sram_reader.sv
`default_nettype none
// ============================================================================
// Module      : sa_down_sram_reader
// Description : Unloads output-stationary results from the systolic array's
//               down (result) SRAM bank. Reads every row of a programmed,
//               possibly wrapping, address window and serialises each
//               NUM_COL-wide row into single accumulator words on a
//               valid/ready stream.
// Ports       : clk, rst            - clock, async active-high reset
//               i_start, i_start_addr, i_end_addr
//                                   - window start pulse and inclusive bounds
//               o_busy, o_done      - activity flag, end-of-window pulse
//               o_down_rd_en, o_down_rd_addr, i_down_rd_data
//                                   - down-SRAM read port
//               o_valid, i_ready, o_data, o_row_addr, o_col_idx, o_last
//                                   - result word stream with position tags
// Revision    : 1.0 - initial release
// ============================================================================
module sa_down_sram_reader #(
    parameter int NUM_COL              = 4,
    parameter int ACCU_DATA_WIDTH      = 32,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int SRAM_RD_LATENCY      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_start_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]     i_end_addr,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_rd_addr,
    input  logic [NUM_COL*ACCU_DATA_WIDTH-1:0]  i_down_rd_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [ACCU_DATA_WIDTH-1:0]          o_data,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_row_addr,
    output logic [((NUM_COL > 1) ? $clog2(NUM_COL) : 1)-1:0] o_col_idx,
    output logic                                o_last
);

    localparam int COL_W  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int WAIT_W = (SRAM_RD_LATENCY > 1) ? $clog2(SRAM_RD_LATENCY) : 1;

    localparam logic [COL_W-1:0]  c_COL_LAST  = COL_W'(NUM_COL - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(SRAM_RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e                              state_q,   state_d;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]     cur_q,     cur_d;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]     end_q,     end_d;
    logic [COL_W-1:0]                    col_q,     col_d;
    logic [WAIT_W-1:0]                   wait_q,    wait_d;
    logic [NUM_COL*ACCU_DATA_WIDTH-1:0]  row_buf_q, row_buf_d;

    logic [ACCU_DATA_WIDTH-1:0]          w_row_words [NUM_COL];
    logic                                w_col_last;
    logic                                w_row_last;

    // View the captured row as an array of words so the current column can be
    // selected with a plain index.
    for (genvar c = 0; c < NUM_COL; c++) begin : g_unpack
        assign w_row_words[c] = row_buf_q[c*ACCU_DATA_WIDTH +: ACCU_DATA_WIDTH];
    end

    assign w_col_last = (col_q == c_COL_LAST);
    assign w_row_last = (cur_q == end_q);

    // ------------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            end_q     <= '0;
            col_q     <= '0;
            wait_q    <= '0;
            row_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            end_q     <= end_d;
            col_q     <= col_d;
            wait_q    <= wait_d;
            row_buf_q <= row_buf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        end_d     = end_q;
        col_d     = col_q;
        wait_d    = wait_q;
        row_buf_d = row_buf_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cur_d   = i_start_addr;
                    end_d   = i_end_addr;
                    state_d = S_RD;
                end
            end

            S_RD: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end

            // The SRAM returns data SRAM_RD_LATENCY cycles after the enable;
            // capture it on the last wait cycle so SEND sees a stable row.
            S_WAIT: begin
                if (wait_q == c_WAIT_LAST) begin
                    row_buf_d = i_down_rd_data;
                    col_d     = '0;
                    state_d   = S_SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            // All stream outputs derive from registered state, so they hold
            // while the sink stalls.
            S_SEND: begin
                if (i_ready) begin
                    if (!w_col_last) begin
                        col_d = col_q + 1'b1;
                    end else if (!w_row_last) begin
                        // Address wraps naturally at the bank depth.
                        cur_d   = cur_q + 1'b1;
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from state only, zero whenever not meaningful
    // ------------------------------------------------------------------------
    always_comb begin
        o_busy         = (state_q != S_IDLE);
        o_done         = (state_q == S_DONE);
        o_down_rd_en   = 1'b0;
        o_down_rd_addr = '0;
        o_valid        = 1'b0;
        o_data         = '0;
        o_row_addr     = '0;
        o_col_idx      = '0;
        o_last         = 1'b0;

        if (state_q == S_RD) begin
            o_down_rd_en   = 1'b1;
            o_down_rd_addr = cur_q;
        end

        if (state_q == S_SEND) begin
            o_valid    = 1'b1;
            o_data     = w_row_words[col_q];
            o_row_addr = cur_q;
            o_col_idx  = col_q;
            o_last     = w_col_last & w_row_last;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sa_down_sram_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_down_sram_reader
// Description : Self-checking bench for sa_down_sram_reader. A queue-based
//               scoreboard is filled from the window rules when a transfer is
//               launched; a monitor pops and compares on every handshake.
//               A second instance with a 3-cycle SRAM read latency covers the
//               latency parameter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_down_sram_reader;

    localparam int NC    = 4;
    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [AW-1:0] row;
        logic [1:0]    col;
        logic          last;
    } exp_t;

    logic clk;
    logic rst;

    // Instance with read latency 1
    logic              i_start;
    logic [AW-1:0]     i_start_addr, i_end_addr;
    logic              o_busy, o_done, rd_en, o_valid, o_last;
    logic [AW-1:0]     rd_addr, o_row_addr;
    logic [NC*W-1:0]   rd_data;
    logic              i_ready;
    logic [W-1:0]      o_data;
    logic [1:0]        o_col_idx;

    // Instance with read latency 3
    logic              i_start3;
    logic [AW-1:0]     i_start_addr3, i_end_addr3;
    logic              o_busy3, o_done3, rd_en3, o_valid3, o_last3;
    logic [AW-1:0]     rd_addr3, o_row_addr3;
    logic [NC*W-1:0]   pipe3 [3];
    logic              i_ready3;
    logic [W-1:0]      o_data3;
    logic [1:0]        o_col_idx3;

    logic [NC*W-1:0]   mem [DEPTH];

    exp_t              exp_q [$];
    logic [AW-1:0]     exp_rd_q [$];
    int                pending_done;
    int                done_cnt;
    int                compared;
    int                mismatched;
    int                cyc;
    int                first_rd, first_valid, t_done;
    int                ready_mode;
    int                ready_k;

    sa_down_sram_reader #(
        .NUM_COL(NC), .ACCU_DATA_WIDTH(W), .LOG2_SRAM_BANK_DEPTH(AW), .SRAM_RD_LATENCY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_start_addr(i_start_addr), .i_end_addr(i_end_addr),
        .o_busy(o_busy), .o_done(o_done),
        .o_down_rd_en(rd_en), .o_down_rd_addr(rd_addr), .i_down_rd_data(rd_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_row_addr(o_row_addr), .o_col_idx(o_col_idx), .o_last(o_last)
    );

    sa_down_sram_reader #(
        .NUM_COL(NC), .ACCU_DATA_WIDTH(W), .LOG2_SRAM_BANK_DEPTH(AW), .SRAM_RD_LATENCY(3)
    ) dut3 (
        .clk(clk), .rst(rst),
        .i_start(i_start3), .i_start_addr(i_start_addr3), .i_end_addr(i_end_addr3),
        .o_busy(o_busy3), .o_done(o_done3),
        .o_down_rd_en(rd_en3), .o_down_rd_addr(rd_addr3), .i_down_rd_data(pipe3[2]),
        .o_valid(o_valid3), .i_ready(i_ready3), .o_data(o_data3),
        .o_row_addr(o_row_addr3), .o_col_idx(o_col_idx3), .o_last(o_last3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // SRAM models: data appears LATENCY cycles after the enable; idle cycles
    // return garbage so a mistimed capture is visible.
    always @(posedge clk) begin
        rd_data  <= rd_en  ? mem[rd_addr]  : {NC{$urandom}};
        pipe3[0] <= rd_en3 ? mem[rd_addr3] : {NC{$urandom}};
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a window covers (end-start) mod depth + 1 rows starting at
    // start, each emitted column 0 first.
    task automatic push_window(input int s, input int e);
        int nrows;
        exp_t x;
        nrows = ((e - s) % DEPTH + DEPTH) % DEPTH + 1;
        for (int r = 0; r < nrows; r++) begin
            int a;
            a = (s + r) % DEPTH;
            exp_rd_q.push_back(AW'(a));
            for (int c = 0; c < NC; c++) begin
                x.data = mem[a][c*W +: W];
                x.row  = AW'(a);
                x.col  = 2'(c);
                x.last = (r == nrows - 1) && (c == NC - 1);
                exp_q.push_back(x);
            end
        end
        pending_done++;
    endtask

    // Sink ready generator: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
    initial begin
        int pat [4];
        pat = '{1, 0, 0, 1};
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       begin i_ready = pat[ready_k % 4] != 0; ready_k++; end
                2:       i_ready = ($urandom % 2) != 0;
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard for the latency-1 instance
    initial begin
        logic        stalled;
        exp_t        held;
        exp_t        act;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                act = '{data: o_data, row: o_row_addr, col: o_col_idx, last: o_last};
                if (o_valid && rd_en)
                    check("valid_with_rd_en", 1, 0);
                if (rd_en) begin
                    if (first_rd < 0) first_rd = cyc;
                    if (exp_rd_q.size() == 0) check("rd_addr_unexpected", 1, 0);
                    else check("rd_addr", 64'(rd_addr), 64'(exp_rd_q.pop_front()));
                end
                if (o_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (stalled) check("held_while_stalled", 64'(act), 64'(held));
                    if (i_ready) begin
                        stalled = 1'b0;
                        if (exp_q.size() == 0) check("word_unexpected", 64'(act), 0);
                        else check("word", 64'(act), 64'(exp_q.pop_front()));
                    end else begin
                        stalled = 1'b1;
                        held    = act;
                    end
                end else if (stalled) begin
                    check("valid_dropped", 0, 1);
                    stalled = 1'b0;
                end
                if (o_done) begin
                    done_cnt++;
                    if (t_done < 0) t_done = cyc;
                    check("done_expected", 64'(pending_done > 0), 1);
                    check("done_words_left", 64'(exp_q.size()), 0);
                    if (pending_done > 0) pending_done--;
                end
            end
        end
    end

    task automatic run_window(input int s, input int e, input bit timing, input bit repulse);
        int T;
        int d0;
        int n;
        int nrows;
        nrows = ((e - s) % DEPTH + DEPTH) % DEPTH + 1;
        push_window(s, e);
        first_rd = -1; first_valid = -1; t_done = -1;
        d0 = done_cnt;
        i_start_addr = AW'(s);
        i_end_addr   = AW'(e);
        i_start      = 1'b1;
        T = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            if (repulse && n == 6) begin
                i_start_addr = AW'($urandom);
                i_end_addr   = AW'($urandom);
                i_start      = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        i_start = 1'b0;
        if (done_cnt == d0) check("done_timeout", 0, 1);
        check("window_words_consumed", 64'(exp_q.size()), 0);
        check("window_reads_consumed", 64'(exp_rd_q.size()), 0);
        if (timing) begin
            check("lat_rd_en",       64'(first_rd),    64'(T + 1));
            check("lat_first_valid", 64'(first_valid), 64'(T + 3));
            check("lat_done",        64'(t_done),      64'(T + nrows * (NC + 2) + 1));
        end
        @(posedge clk); #1;
        check("idle_after_done", 64'(o_busy), 0);
    endtask

    initial begin
        int n;
        int T3;
        int fv3, td3, cnt3;
        compared = 0; mismatched = 0;
        pending_done = 0; done_cnt = 0;
        first_rd = -1; first_valid = -1; t_done = -1;
        ready_mode = 0; ready_k = 0;
        i_start = 0; i_start_addr = '0; i_end_addr = '0;
        i_start3 = 0; i_start_addr3 = '0; i_end_addr3 = '0; i_ready3 = 1'b1;
        for (int a = 0; a < DEPTH; a++)
            mem[a] = {$urandom, $urandom, $urandom, $urandom};
        mem[3] = {32'd40, 32'd30, 32'd20, 32'd10};

        // Reset applied with no clock edge yet: outputs must already be zero
        rst = 1'b1;
        #2;
        check("reset_outputs",
              64'({o_busy, o_done, rd_en, rd_addr, o_valid, o_data, o_row_addr, o_col_idx, o_last}), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'(o_busy), 0);
        @(posedge clk); #1;

        // Single row with exact latency
        run_window(3, 3, 1'b1, 1'b0);
        // Multi-row window with latency
        run_window(0, 3, 1'b1, 1'b0);
        // Wrap-around
        run_window(30, 1, 1'b0, 1'b0);
        // Backpressure 1,0,0,1
        ready_mode = 1; ready_k = 0;
        run_window(0, 3, 1'b0, 1'b0);
        // Whole bank
        ready_mode = 0;
        run_window(0, DEPTH - 1, 1'b0, 1'b0);
        // Start re-pulsed while busy is ignored
        ready_mode = 2;
        run_window(10, 12, 1'b0, 1'b1);
        // Randomised windows under random backpressure
        for (int k = 0; k < 6; k++) begin
            int s;
            s = int'($urandom % DEPTH);
            run_window(s, (s + int'($urandom % 6)) % DEPTH, 1'b0, ($urandom % 2) != 0);
        end

        // Reset during SEND of row 1 abandons the transfer without o_done
        ready_mode = 0;
        push_window(0, 3);
        i_start_addr = 5'd0; i_end_addr = 5'd3; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_valid && o_row_addr == 5'd1) && n < 100);
        if (n >= 100) check("reach_row1_timeout", 0, 1);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_send_outputs",
              64'({o_busy, o_done, rd_en, rd_addr, o_valid, o_data, o_row_addr, o_col_idx, o_last}), 0);
        exp_q.delete();
        exp_rd_q.delete();
        pending_done = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_abort", 64'(o_busy), 0);
        @(posedge clk); #1;
        // A fresh start after the abort runs cleanly
        ready_mode = 2;
        run_window(5, 9, 1'b0, 1'b0);

        // Latency-3 instance: first valid at T+5, done at T+9
        i_start_addr3 = 5'd7; i_end_addr3 = 5'd7; i_start3 = 1'b1;
        T3 = cyc;
        @(posedge clk); #1 i_start3 = 1'b0;
        fv3 = -1; td3 = -1; cnt3 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_valid3) begin
                if (fv3 < 0) fv3 = cyc;
                if (cnt3 < NC) begin
                    check("lat3_word", 64'({o_data3, o_col_idx3, o_last3}),
                          64'({mem[7][cnt3*W +: W], 2'(cnt3), cnt3 == NC - 1}));
                end
                cnt3++;
            end
            if (o_done3 && td3 < 0) td3 = cyc;
        end
        check("lat3_first_valid", 64'(fv3), 64'(T3 + 5));
        check("lat3_word_count",  64'(cnt3), 64'(NC));
        check("lat3_done",        64'(td3), 64'(T3 + 9));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
